tf32_operand_fetch: RTL and testbench

- Upstream stage of the TF32 multiplier datapath. Sequences a shared read address into two single-port operand ROMs: num1 bank and num2 bank.
- Absorbs the ROM read latency. Delivers aligned 19-bit TF32 operand pairs {sign, exp[7:0], frac[9:0]} to the multiplier over a valid/ready handshake.
- Replaces the free-running address counter with a start/count-controlled, back-pressurable streamer.

---
 rtl/tf32_operand_fetch_if.sv | 12 +
 rtl/tf32_operand_fetch.sv | 186 ++++++++++++++++++
 tb/tb_tf32_operand_fetch.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/tf32_operand_fetch_if.sv
// Operand stream from the TF32 operand fetch stage to the multiplier.
// The master drives an aligned operand pair with a valid/last qualifier; the slave returns ready.
interface tf32_operand_fetch_if;
   logic [18:0] op_a;
   logic [18:0] op_b;
   logic        op_valid;
   logic        op_ready;
   logic        op_last;

   modport master (output op_a, output op_b, output op_valid, output op_last, input op_ready);
   modport slave  (input op_a, input op_b, input op_valid, input op_last, output op_ready);
endinterface

// File: rtl/tf32_operand_fetch.sv
// Burst streamer that reads paired TF32 operands from two ROM banks and hides the ROM latency behind a credit-checked FIFO.
// Optional macro TF32_DAZ_EN: operands with a zero exponent have their fraction cleared at FIFO write.
module tf32_operand_fetch #(
   parameter int ADDR_W     = 14,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [18:0]       mem_dout_a,
   input  logic [18:0]       mem_dout_b,
   tf32_operand_fetch_if.master op
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

   state_t              state_r, state_s;
   logic                busy_r, done_r, done_s;
   logic                mem_en_r, mem_en_nxt_s;
   logic [ADDR_W-1:0]   addr_r;
   logic [ADDR_W:0]     remaining_r;
   logic [RD_LAT-1:0]   tag_r, tag_last_r;
   logic [CNT_W-1:0]    occ_r, occ_nxt_s, inflight_r, inflight_nxt_s;
   logic [CNT_W:0]      credit_s;
   logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
   logic [18:0]         fifo_a_r [FIFO_DEPTH];
   logic [18:0]         fifo_b_r [FIFO_DEPTH];
   logic                fifo_last_r [FIFO_DEPTH];
   logic                push_s, pop_s, op_valid_s;

   // Denormal-as-zero: clear the fraction of a zero-exponent operand, keep its sign.
   function automatic logic [18:0] daz_f(input logic [18:0] val);
`ifdef TF32_DAZ_EN
      if (val[17:10] == 8'h00) begin
         daz_f = {val[18:10], 10'h000};
      end else begin
         daz_f = val;
      end
`else
      daz_f = val;
`endif
   endfunction

   // Occupancy/in-flight bookkeeping and the credit that gates the next ROM read.
   always_comb begin
      push_s     = tag_r[RD_LAT-1];
      op_valid_s = (occ_r != {CNT_W{1'b0}});
      pop_s      = op_valid_s & op.op_ready;
      occ_nxt_s  = occ_r;
      case ({push_s, pop_s})
         2'b10:   occ_nxt_s = occ_r + CNT_W'(1'b1);
         2'b01:   occ_nxt_s = occ_r - CNT_W'(1'b1);
         default: occ_nxt_s = occ_r;
      endcase
      inflight_nxt_s = inflight_r;
      case ({mem_en_r, push_s})
         2'b10:   inflight_nxt_s = inflight_r + CNT_W'(1'b1);
         2'b01:   inflight_nxt_s = inflight_r - CNT_W'(1'b1);
         default: inflight_nxt_s = inflight_r;
      endcase
      credit_s     = {1'b0, occ_nxt_s} + {1'b0, inflight_nxt_s};
      mem_en_nxt_s = (state_s == ISSUE) && (credit_s < DEPTH_C);
   end

   // Next-state and done-pulse decode.
   always_comb begin
      state_s = state_r;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (count != {(ADDR_W+1){1'b0}}) begin
                  state_s = ISSUE;
               end else begin
                  done_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (mem_en_r && (remaining_r == (ADDR_W+1)'(1'b1))) begin
               state_s = DRAIN;
            end else begin
               state_s = ISSUE;
            end
         end
         DRAIN: begin
            if ((occ_nxt_s == {CNT_W{1'b0}}) && (inflight_nxt_s == {CNT_W{1'b0}})) begin
               state_s = IDLE;
               done_s  = 1'b1;
            end else begin
               state_s = DRAIN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Burst control: state, status flags, address/remaining counters, registered ROM enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         mem_en_r    <= 1'b0;
         addr_r      <= {ADDR_W{1'b0}};
         remaining_r <= {(ADDR_W+1){1'b0}};
      end else begin
         state_r  <= state_s;
         busy_r   <= (state_s != IDLE);
         done_r   <= done_s;
         mem_en_r <= mem_en_nxt_s;
         if ((state_r == IDLE) && (state_s == ISSUE)) begin
            addr_r      <= base_addr;
            remaining_r <= count;
         end else if (mem_en_r) begin
            addr_r      <= addr_r + ADDR_W'(1'b1);
            remaining_r <= remaining_r - (ADDR_W+1)'(1'b1);
         end
      end
   end

   // Read-latency tag pipeline; clearing it on reset discards responses still in the ROM.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_r      <= {RD_LAT{1'b0}};
         tag_last_r <= {RD_LAT{1'b0}};
         inflight_r <= {CNT_W{1'b0}};
      end else begin
         tag_r[0]      <= mem_en_r;
         tag_last_r[0] <= mem_en_r && (remaining_r == (ADDR_W+1)'(1'b1));
         for (int i = 1; i < RD_LAT; i++) begin
            tag_r[i]      <= tag_r[i-1];
            tag_last_r[i] <= tag_last_r[i-1];
         end
         inflight_r <= inflight_nxt_s;
      end
   end

   // Output FIFO storage and pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         occ_r    <= {CNT_W{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_a_r[i]    <= 19'h00000;
            fifo_b_r[i]    <= 19'h00000;
            fifo_last_r[i] <= 1'b0;
         end
      end else begin
         if (push_s) begin
            fifo_a_r[wr_ptr_r]    <= daz_f(mem_dout_a);
            fifo_b_r[wr_ptr_r]    <= daz_f(mem_dout_b);
            fifo_last_r[wr_ptr_r] <= tag_last_r[RD_LAT-1];
            wr_ptr_r              <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         occ_r <= occ_nxt_s;
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign mem_en      = mem_en_r;
   assign mem_addr    = addr_r;
   assign op.op_valid = op_valid_s;
   assign op.op_a     = fifo_a_r[rd_ptr_r];
   assign op.op_b     = fifo_b_r[rd_ptr_r];
   assign op.op_last  = fifo_last_r[rd_ptr_r];

endmodule

// File: tb/tb_tf32_operand_fetch.sv
// Directed bench for tf32_operand_fetch: ROM model with a[i]=1FC00+i, b[i]=20000+i, special DAZ words at 100/101.
module tb_tf32_operand_fetch;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [13:0] base_addr;
   logic [14:0] count;
   logic        busy, done, mem_en;
   logic [13:0] mem_addr;
   logic [18:0] mem_dout_a = 19'h00000;
   logic [18:0] mem_dout_b = 19'h00000;
   int          n_cmp = 0;
   int          n_bad = 0;

   tf32_operand_fetch_if ifc ();

   tf32_operand_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .mem_en     (mem_en),
      .mem_addr   (mem_addr),
      .mem_dout_a (mem_dout_a),
      .mem_dout_b (mem_dout_b),
      .op         (ifc)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] rom_a(input logic [13:0] addr);
      if (addr == 14'd100)      rom_a = 19'h00155;
      else if (addr == 14'd101) rom_a = 19'h40155;
      else                      rom_a = 19'h1FC00 + {5'd0, addr};
   endfunction

   function automatic logic [18:0] rom_b(input logic [13:0] addr);
      rom_b = 19'h20000 + {5'd0, addr};
   endfunction

   function automatic logic [18:0] exp_a(input logic [13:0] addr);
`ifdef TF32_DAZ_EN
      if (addr == 14'd100)      exp_a = 19'h00000;
      else if (addr == 14'd101) exp_a = 19'h40000;
      else                      exp_a = rom_a(addr);
`else
      exp_a = rom_a(addr);
`endif
   endfunction

   // Single-port ROM banks, one cycle read latency
   always @(posedge clk) begin
      if (mem_en) begin
         mem_dout_a <= rom_a(mem_addr);
         mem_dout_b <= rom_b(mem_addr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one burst from IDLE; entered just after a negedge. stall selects the 1,0,0,1,1,0,1,0 ready pattern.
   task automatic run_burst(input logic [13:0] base, input logic [14:0] cnt, input bit stall, input string tag);
      int          idx = 0;
      int          last_cyc = -10;
      int          ndone = 0;
      logic        stalled = 1'b0;
      logic [18:0] held_a = 19'h00000;
      logic [13:0] ea;
      bit          seen_valid = 1'b0;
      logic [7:0]  pat = 8'b0101_1001;
      start = 1'b1; base_addr = base; count = cnt;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         if (cyc == 1) chk({tag, "_busy"}, busy, 1);
         start = (stall && (cyc == 3));
         if (start) begin base_addr = 14'h1234; count = 15'd9; end
         ifc.op_ready = stall ? pat[cyc % 8] : 1'b1;
         if (!seen_valid && ifc.op_valid) begin
            seen_valid = 1'b1;
            chk({tag, "_latency"}, cyc, 3);
         end
         if (stalled) begin
            chk({tag, "_hold_valid"}, ifc.op_valid, 1);
            chk({tag, "_hold_a"}, ifc.op_a, held_a);
         end
         chk({tag, "_credit"}, ((dut.occ_r + dut.inflight_r) <= 4), 1);
         if (done) ndone++;
         if (cyc == last_cyc + 1) begin
            chk({tag, "_done"}, done, 1);
            chk({tag, "_busy_low"}, busy, 0);
            break;
         end
         if (ifc.op_valid && ifc.op_ready) begin
            ea = base + 14'(idx);
            chk({tag, "_a"}, ifc.op_a, exp_a(ea));
            chk({tag, "_b"}, ifc.op_b, rom_b(ea));
            chk({tag, "_last"}, ifc.op_last, (idx == int'(cnt) - 1));
            idx++;
            if (idx == int'(cnt)) last_cyc = cyc;
         end
         stalled = ifc.op_valid && !ifc.op_ready;
         held_a  = ifc.op_a;
      end
      chk({tag, "_pairs"}, idx, cnt);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_done_count"}, ndone, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = 14'd0; count = 15'd0; ifc.op_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_valid", ifc.op_valid, 0);
      chk("rst_last", ifc.op_last, 0);
      chk("rst_op_a", ifc.op_a, 0);
      chk("rst_op_b", ifc.op_b, 0);
      rst = 1'b0;
      @(negedge clk);

      run_burst(14'd0, 15'd4, 1'b0, "b4");
      run_burst(14'd20, 15'd16, 1'b1, "b16");
      ifc.op_ready = 1'b1;
      run_burst(14'h3FFE, 15'd4, 1'b0, "wrap");

      // count = 0: no reads, no data, one done pulse
      start = 1'b1; base_addr = 14'd7; count = 15'd0;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_mem_en", mem_en, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("zero_done_clr", done, 0);
         chk("zero_valid", ifc.op_valid, 0);
         chk("zero_mem_en_idle", mem_en, 0);
      end

      // reset two cycles into a burst
      start = 1'b1; base_addr = 14'd0; count = 15'd8;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", ifc.op_valid, 0);
      chk("abort_mem_en", mem_en, 0);
      chk("abort_done", done, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_valid_idle", ifc.op_valid, 0);
         chk("abort_done_idle", done, 0);
      end
      run_burst(14'd5, 15'd2, 1'b0, "after_rst");

      run_burst(14'd100, 15'd2, 1'b0, "daz");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
